// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the unified memory responder: funct3 access modes and FSM encoding.
package riscv_mem_pkg;

    localparam logic [2:0] MODE_B  = 3'b000;
    localparam logic [2:0] MODE_H  = 3'b001;
    localparam logic [2:0] MODE_W  = 3'b010;
    localparam logic [2:0] MODE_BU = 3'b100;
    localparam logic [2:0] MODE_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC1 = 2'd1,
        ST_ACC2 = 2'd2,
        ST_RESP = 2'd3
    } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for data accesses: store mask/shift, load extract/extend, and
// misalignment or reserved-mode detection.
module mem_lane_align
    import riscv_mem_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  mode,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  wmask,
    output logic [31:0] wshift,
    output logic [31:0] rdata,
    output logic        err
);

    logic [31:0] shifted;

    always_comb begin
        wmask   = 4'b0000;
        rdata   = 32'h0;
        err     = 1'b0;
        shifted = rword >> {off, 3'b000};
        wshift  = wdata << {off, 3'b000};
        case (mode)
            MODE_B, MODE_BU: begin
                wmask = 4'b0001 << off;
                rdata = mode[2] ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
            end
            MODE_H, MODE_HU: begin
                err   = off[0];
                wmask = 4'b0011 << off;
                rdata = mode[2] ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            end
            MODE_W: begin
                err   = (off != 2'b00);
                wmask = 4'b1111;
                rdata = shifted;
            end
            default: err = 1'b1;
        endcase
        // unsigned modes have no store counterpart
        if (we && mode[2]) begin
            err = 1'b1;
        end
        if (err) begin
            wmask = 4'b0000;
            rdata = 32'h0;
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Single-port word memory shared by fetch and data initiators, with wait states,
// split-halfword fetches, starvation-bounded arbitration and one-cycle ready pulses.
//
//  state | meaning
//  IDLE  | no transaction; arbitrate and latch the winning request
//  ACC1  | first word access, WAIT_CYCLES+1 cycles; stores commit on exit
//  ACC2  | second word of a split fetch, WAIT_CYCLES+1 cycles
//  RESP  | single ready pulse to the granted initiator
module mem_responder
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int WAIT_CYCLES = 1,
    parameter int STARVE_MAX  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [2:0]  d_mode,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        busy
);

    localparam int IW    = ADDR_W - 2;
    localparam int WORDS = 1 << IW;
    localparam int SW    = $clog2(STARVE_MAX + 1);

    state_t            state_q, state_d;
    logic [3:0]        wait_q, wait_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic              fetch_q, fetch_d;
    logic              we_q, we_d;
    logic [2:0]        mode_q, mode_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       res_q, res_d;

    logic [31:0]       mem [WORDS];
    logic [IW-1:0]     word_idx, next_idx;
    logic              grant_f, grant_d, mem_we;
    logic [3:0]        lane_wmask;
    logic [31:0]       lane_wdata, lane_rdata;
    logic              lane_err;
    logic              unused_addr_hi;

    assign unused_addr_hi = ^{if_addr[31:ADDR_W], d_addr[31:ADDR_W]};

    assign word_idx = addr_q[ADDR_W-1:2];
    assign next_idx = word_idx + IW'(1);

    assign grant_f = if_req && (!d_req || (starve_q == SW'(STARVE_MAX)));
    assign grant_d = d_req && !grant_f;

    mem_lane_align u_align (
        .we     (we_q),
        .mode   (mode_q),
        .off    (addr_q[1:0]),
        .wdata  (wdata_q),
        .rword  (mem[word_idx]),
        .wmask  (lane_wmask),
        .wshift (lane_wdata),
        .rdata  (lane_rdata),
        .err    (lane_err)
    );

    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        starve_d = starve_q;
        fetch_d  = fetch_q;
        we_d     = we_q;
        mode_d   = mode_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        res_d    = res_q;
        mem_we   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_f || grant_d) begin
                    state_d = ST_ACC1;
                    wait_d  = 4'(WAIT_CYCLES);
                    fetch_d = grant_f;
                    res_d   = 32'h0;
                    if (grant_f) begin
                        starve_d = '0;
                        addr_d   = if_addr[ADDR_W-1:0];
                        we_d     = 1'b0;
                        mode_d   = MODE_W;
                        wdata_d  = 32'h0;
                    end else begin
                        starve_d = if_req ? starve_q + SW'(1) : '0;
                        addr_d   = d_addr[ADDR_W-1:0];
                        we_d     = d_we;
                        mode_d   = d_mode;
                        wdata_d  = d_wdata;
                    end
                end
            end
            ST_ACC1: begin
                if (wait_q != 4'd0) begin
                    wait_d = wait_q - 4'd1;
                end else begin
                    wait_d = 4'(WAIT_CYCLES);
                    if (fetch_q && addr_q[1]) begin
                        res_d   = {16'h0, mem[word_idx][31:16]};
                        state_d = ST_ACC2;
                    end else if (fetch_q) begin
                        res_d   = mem[word_idx];
                        state_d = ST_RESP;
                    end else begin
                        res_d   = we_q ? 32'h0 : lane_rdata;
                        mem_we  = we_q && !lane_err;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_ACC2: begin
                if (wait_q != 4'd0) begin
                    wait_d = wait_q - 4'd1;
                end else begin
                    res_d   = {mem[next_idx][15:0], res_q[15:0]};
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            wait_q   <= 4'd0;
            starve_q <= '0;
            fetch_q  <= 1'b0;
            we_q     <= 1'b0;
            mode_q   <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= 32'h0;
            res_q    <= 32'h0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            starve_q <= starve_d;
            fetch_q  <= fetch_d;
            we_q     <= we_d;
            mode_q   <= mode_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            res_q    <= res_d;
        end
    end

    // array contents survive reset; writes are gated by state, so an aborted store never lands
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (lane_wmask[b]) begin
                    mem[word_idx][8*b +: 8] <= lane_wdata[8*b +: 8];
                end
            end
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign if_ready = (state_q == ST_RESP) && fetch_q;
    assign d_ready  = (state_q == ST_RESP) && !fetch_q;
    assign if_rdata = if_ready ? res_q : 32'h0;
    assign d_rdata  = d_ready ? res_q : 32'h0;
    assign d_err    = d_ready && lane_err;

endmodule
